// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: four-way round-robin arbiter driving a 4:1 single-bit mux.
// The owner keeps the path for at most MAX_BURST consecutive cycles while
// anyone else is waiting; ownership then rotates by a priority pointer that
// always points one past the most recent new grant.
module mux_rr_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] in,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       valid,
  output logic       out
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  // Burst count value at which the owner must give way to waiting requesters.
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  state_t     state;
  logic [1:0] ptr;
  logic [3:0] burst_cnt;

  logic [3:0] cand;
  logic       pick_found;
  logic [1:0] pick_idx;
  logic       owner_stays;
  logic       take_new;

  // First set bit of mask scanning upward from start, wrapping 3->0.
  // Returns {found, index}; the downward loop lets the closest hit win last.
  function automatic logic [2:0] rr_pick(input logic [3:0] mask,
                                         input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (mask[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  // Choose the next owner candidate and decide whether a new grant is taken.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    cand        = req;
    owner_stays = 1'b0;
    take_new    = 1'b0;
    if (state == BUSY) begin
      // The current owner is never a rotation candidate for itself.
      cand        = req & ~grant;
      owner_stays = req[sel] && (burst_cnt < BURST_LAST);
    end
    {pick_found, pick_idx} = rr_pick(cand, ptr);
    take_new = pick_found && !owner_stays;
  end

  // Arbitration state: owner, pointer and burst count, all registered.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: asynchronous reset clears every register at once, independent of clk.
    if (rst) begin
      state     <= IDLE;
      grant     <= 4'b0000;
      sel       <= 2'd0;
      valid     <= 1'b0;
      ptr       <= 2'd0;
      burst_cnt <= 4'd0;
    end else if (take_new) begin
      // NOTE: non-blocking assignments keep all state updates on the same edge.
      state     <= BUSY;
      grant     <= 4'b0001 << pick_idx;
      sel       <= pick_idx;
      valid     <= 1'b1;
      ptr       <= pick_idx + 2'd1;
      burst_cnt <= 4'd0;
    end else if (state == BUSY) begin
      if (owner_stays) begin
        burst_cnt <= burst_cnt + 4'd1;
      end else if (req[sel]) begin
        // Burst limit reached with nobody waiting: keep owner, restart burst.
        burst_cnt <= 4'd0;
      end else begin
        state     <= IDLE;
        grant     <= 4'b0000;
        sel       <= 2'd0;
        valid     <= 1'b0;
        burst_cnt <= 4'd0;
      end
    end
  end

  // Route the owner's data bit; forced low while nobody owns the path.
  assign out = valid & in[sel];

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, maximum consecutive grant cycles for one owner while others wait (legal range 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req  input  4  request per requester; bit i = requester i.
REQ-005 SHALL have port in  input  4  data bit per requester; bit i is routed when requester i owns the path.
REQ-006 SHALL have port grant  output  4  registered one-hot grant, or all-zero when idle.
REQ-007 SHALL have port sel  output  2  registered binary index of the current owner, driving the 4:1 select.
REQ-008 SHALL have port valid  output  1  registered; high when grant is non-zero.
REQ-009 SHALL have port out  output  1  in[sel] when valid=1, else 0 (combinational from registered sel/valid).

Function
REQ-010 SHALL implement two states: IDLE (no owner) and BUSY (owner = sel).
REQ-011 SHALL, in IDLE with req!=0, enter BUSY on the next edge, granting the first set req bit scanning upward from ptr, wrapping 3->0.
REQ-012 SHALL keep a 2-bit priority pointer ptr; each new grant to requester k sets ptr = k+1 mod 4.
REQ-013 SHALL have one-cycle latency: a req first sampled at edge n is visible on grant/sel/valid after edge n, never combinationally.
REQ-014 SHALL, in BUSY, hold the owner while req[sel]=1 and burst count < MAX_BURST-1.
REQ-015 SHALL count owner cycles in a 4-bit burst counter; it resets to 0 on every new grant.
REQ-016 SHALL, when req[sel] drops, release on that edge: if any other req is set, grant the next one by round-robin from ptr with no idle cycle; otherwise go to IDLE with grant=0.
REQ-017 SHALL, when burst count = MAX_BURST-1 and any other req is set, rotate ownership on that edge to the next requester by round-robin from ptr.
REQ-018 SHALL, when burst count = MAX_BURST-1 and no other req is set, keep the owner and reset the burst count to 0.
REQ-019 SHALL, with MAX_BURST=1, rotate every cycle among active requesters.
REQ-020 SHALL guarantee grant is one-hot or zero, and that valid = |grant and sel = index(grant) in every cycle.
REQ-021 SHALL never grant a requester whose req bit was 0 at the granting edge.
REQ-022 SHALL bound wait: any continuously asserted req is granted within 3*MAX_BURST+1 cycles.

Reset
REQ-023 SHALL, while rst=1, immediately force grant=0, sel=0, valid=0, out=0, ptr=0, burst count=0 and state IDLE, independent of clk.
REQ-024 SHALL, on rst asserted mid-BUSY, drop the grant asynchronously and drop any in-flight burst; after release, arbitration restarts from ptr=0.
REQ-025 SHALL resume arbitration on the first rising clk edge after rst deasserts.

Verification
REQ-026 Case 1: reset, then req=0001 at edge 1 -> grant=0001, sel=0, valid=1 after edge 1; set in=0001 -> out=1; req=0000 -> grant=0000 and valid=0 after the next edge.
REQ-027 Case 2: req=1111 held with MAX_BURST=4 -> owners 0,1,2,3,0, each held for exactly 4 cycles, with no gap cycles.
REQ-028 Case 3: owner 2 with req=0100, then req=1000 set and req[2] cleared on the same edge -> grant=1000 on that edge, with no IDLE cycle.
REQ-029 Case 4: req=0010 only, held for 10 cycles -> grant=0010 throughout; the burst count wraps silently.
REQ-030 Case 5: owner 1 mid-burst and rst pulsed between clock edges -> grant=0 and valid=0 immediately; after release with req=1111, the first grant is 0001 (ptr=0).
REQ-031 Case 6: random req for 10k cycles -> a checker confirms REQ-020, REQ-021, REQ-022 and out==in[sel] whenever valid=1.
